spi_xfer_ctrl: RTL and testbench

- Master-mode transfer sequencer for the SPI peripheral.
- On a start pulse it captures the transfer configuration, asserts slave select, and generates SCK at the configured divide ratio. It shifts 8/16/24/32 bits out on MOSI and in from MISO, honouring CPOL/CPHA and LSB-first, then releases slave select and pulses done.
- Sits between the APB4 register file (ctrl/tx/rx registers) and the SPI pads; the register file drives its config inputs and its busy status bit.

---
 rtl/spi_xfer_ctrl_pkg.sv | 21 ++
 rtl/spi_xfer_ctrl_tick_gen.sv | 27 ++
 rtl/spi_xfer_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared SPI definitions: transfer sequencer states and the dtb encoding.
package spi_xfer_ctrl_pkg;

    localparam int DIV_W        = 8;
    localparam int BITCNT_W     = 7;
    localparam int BITS_PER_DTB = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } xfer_state_t;

    // dtb holds (bytes - 1); returns the frame length in bits (8/16/24/32).
    function automatic logic [BITCNT_W-1:0] dtb_to_bits(input logic [1:0] dtb);
        return (BITCNT_W'(dtb) + BITCNT_W'(1)) * BITCNT_W'(BITS_PER_DTB);
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_tick_gen.sv
// Reloadable SCK half-period divider: tick every load_i+1 cycles after clear.
module spi_tick_gen
    import spi_xfer_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] load_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] r_cnt;

    // Down-counter: reload on clear or terminal count, otherwise decrement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i || (r_cnt == '0)) begin
            r_cnt <= load_i;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign tick_o = (r_cnt == '0) && !clr_i;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: frames 8..32 bits with CPOL/CPHA/LSB-first.
//
//   state | meaning
//   IDLE  | SCK at cpol_i, NSS follows nss_sel_i when ass_i=0, wait for start
//   LEAD  | NSS asserted, first bit on MOSI (cpha=0), one half-period of setup
//   XFER  | 2N SCK edges; even = leading, odd = trailing
//   TRAIL | SCK idle, NSS still asserted, one half-period of hold
//   DONE  | one cycle: done_o pulse, rx_data_o updated, auto NSS released
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSS_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [1:0]        dtb_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_i,
    input  logic              ass_i,
    input  logic [NSS_W-1:0]  nss_sel_i,
    input  logic              miso_i,
    output logic              sck_o,
    output logic              mosi_o,
    output logic [NSS_W-1:0]  nss_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rx_data_o
);

    localparam int IW = $clog2(DATA_W);
    localparam int EW = $clog2(2 * DATA_W);

    // Position of frame bit b (0 = first on the wire) inside the word.
    function automatic logic [IW-1:0] bit_idx(input logic [BITCNT_W-1:0] b,
                                              input logic [BITCNT_W-1:0] n,
                                              input logic                lsb);
        logic [BITCNT_W-1:0] t;
        t = lsb ? b : (n - BITCNT_W'(1) - b);
        return t[IW-1:0];
    endfunction

    xfer_state_t         r_state, w_state;

    logic [DATA_W-1:0]   r_tx;
    logic [BITCNT_W-1:0] r_nbits;
    logic [DIV_W-1:0]    r_div;
    logic                r_cpol, r_cpha, r_lsb, r_ass;
    logic [NSS_W-1:0]    r_nss_sel;

    logic [EW-1:0]       r_edge, w_edge;
    logic [DATA_W-1:0]   r_rx, w_rx;
    logic                r_sck, w_sck;
    logic                r_mosi, w_mosi;
    logic [NSS_W-1:0]    r_nss, w_nss;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic [DATA_W-1:0]   r_rx_out, w_rx_out;

    logic                w_capture;
    logic                w_tick;
    logic                w_tick_clr;
    logic [DIV_W-1:0]    w_tick_load;
    logic [BITCNT_W-1:0] w_k;
    logic                w_last;

    // The divider is held cleared in IDLE and preloaded with the incoming div,
    // so LEAD starts with a full half-period.
    assign w_tick_clr  = (r_state == ST_IDLE);
    assign w_tick_load = (r_state == ST_IDLE) ? div_i : r_div;

    spi_tick_gen u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_tick_clr),
        .load_i (w_tick_load),
        .tick_o (w_tick)
    );

    assign w_k    = BITCNT_W'(r_edge);
    assign w_last = (w_k == ((r_nbits << 1) - BITCNT_W'(1)));

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state   = r_state;
        w_sck     = r_sck;
        w_mosi    = r_mosi;
        w_nss     = r_nss;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_rx_out  = r_rx_out;
        w_edge    = r_edge;
        w_rx      = r_rx;
        w_capture = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_sck  = cpol_i;
                w_busy = 1'b0;
                w_nss  = ass_i ? {NSS_W{1'b1}} : ~nss_sel_i;
                if (start_i) begin
                    w_state   = ST_LEAD;
                    w_capture = 1'b1;
                    w_busy    = 1'b1;
                    w_nss     = ~nss_sel_i;
                    w_edge    = '0;
                    w_rx      = '0;
                    if (!cpha_i) begin
                        w_mosi = tx_data_i[bit_idx('0, dtb_to_bits(dtb_i), lsb_i)];
                    end
                end
            end

            ST_LEAD: begin
                w_sck = r_cpol;
                if (w_tick) begin
                    w_state = ST_XFER;
                    w_edge  = '0;
                end
            end

            ST_XFER: begin
                if (w_tick) begin
                    w_sck  = ~r_sck;
                    w_edge = r_edge + EW'(1);
                    // Sampling edge is leading for cpha=0, trailing for cpha=1.
                    if (r_edge[0] == r_cpha) begin
                        w_rx[bit_idx(w_k >> 1, r_nbits, r_lsb)] = miso_i;
                    end else if (!w_last) begin
                        w_mosi = r_tx[bit_idx((w_k + BITCNT_W'(1)) >> 1, r_nbits, r_lsb)];
                    end
                    if (w_last) begin
                        w_state = ST_TRAIL;
                    end
                end
            end

            ST_TRAIL: begin
                w_sck = r_cpol;
                if (w_tick) begin
                    w_state  = ST_DONE;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    w_rx_out = r_rx;
                    if (r_ass) begin
                        w_nss = {NSS_W{1'b1}};
                    end
                end
            end

            ST_DONE: begin
                w_state = ST_IDLE;
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // Configuration snapshot taken when a start is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx      <= '0;
            r_nbits   <= BITCNT_W'(BITS_PER_DTB);
            r_div     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_ass     <= 1'b1;
            r_nss_sel <= '0;
        end else if (w_capture) begin
            r_tx      <= tx_data_i;
            r_nbits   <= dtb_to_bits(dtb_i);
            r_div     <= div_i;
            r_cpol    <= cpol_i;
            r_cpha    <= cpha_i;
            r_lsb     <= lsb_i;
            r_ass     <= ass_i;
            r_nss_sel <= nss_sel_i;
        end
    end

    // Output and shift registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_nss    <= {NSS_W{1'b1}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rx_out <= '0;
            r_edge   <= '0;
            r_rx     <= '0;
        end else begin
            r_sck    <= w_sck;
            r_mosi   <= w_mosi;
            r_nss    <= w_nss;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_rx_out <= w_rx_out;
            r_edge   <= w_edge;
            r_rx     <= w_rx;
        end
    end

    assign sck_o     = r_sck;
    assign mosi_o    = r_mosi;
    assign nss_o     = r_nss;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign rx_data_o = r_rx_out;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] tx_data_i;
    logic [1:0]  dtb_i;
    logic [7:0]  div_i;
    logic        cpol_i, cpha_i, lsb_i, ass_i;
    logic [3:0]  nss_sel_i;
    logic        miso_fix, loop_en;
    logic        miso_i;
    logic        sck_o, mosi_o, busy_o, done_o;
    logic [3:0]  nss_o;
    logic [31:0] rx_data_o;

    int checks = 0;
    int errors = 0;

    int          m_busy, m_done, m_rise, m_tog, m_gap_min, m_gap_max, m_nss_bad, m_nrec;
    logic [31:0] m_rx;
    logic [63:0] m_mosi;
    bit          m_timeout;

    assign miso_i = loop_en ? mosi_o : miso_fix;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DATA_W(32), .NSS_W(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .tx_data_i (tx_data_i),
        .dtb_i     (dtb_i),
        .div_i     (div_i),
        .cpol_i    (cpol_i),
        .cpha_i    (cpha_i),
        .lsb_i     (lsb_i),
        .ass_i     (ass_i),
        .nss_sel_i (nss_sel_i),
        .miso_i    (miso_i),
        .sck_o     (sck_o),
        .mosi_o    (mosi_o),
        .nss_o     (nss_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rx_data_o (rx_data_o)
    );

    task automatic set_cfg(input logic [31:0] tx, input logic [1:0] dtb, input logic [7:0] dv,
                           input logic cpol, input logic cpha, input logic lsb,
                           input logic ass, input logic [3:0] sel, input logic lp,
                           input logic mfix);
        @(negedge clk);
        tx_data_i = tx; dtb_i = dtb; div_i = dv; cpol_i = cpol; cpha_i = cpha;
        lsb_i = lsb; ass_i = ass; nss_sel_i = sel; loop_en = lp; miso_fix = mfix;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Observes one transfer from the first cycle after the accepted start.
    task automatic measure(input int max_cyc, input logic [3:0] exp_nss, input logic ass_exp,
                           input int inj_cyc, input bit start_in_done);
        int   cyc;
        int   post;
        int   last_tog;
        int   gap;
        logic prev_sck;
        cyc = 0; post = -1; last_tog = -1; prev_sck = sck_o;
        m_busy = 0; m_done = 0; m_rise = 0; m_tog = 0; m_nss_bad = 0; m_nrec = 0;
        m_gap_min = 1000000; m_gap_max = 0; m_rx = '0; m_mosi = '0; m_timeout = 1'b0;
        forever begin
            if (cyc == inj_cyc) begin
                start_i = 1'b1;
                tx_data_i = ~tx_data_i; dtb_i = ~dtb_i; div_i = 8'd0;
                lsb_i = ~lsb_i; cpol_i = ~cpol_i; cpha_i = ~cpha_i; nss_sel_i = ~nss_sel_i;
            end else if (start_in_done && done_o) begin
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (busy_o) begin
                m_busy++;
                if (sck_o !== prev_sck) begin
                    m_tog++;
                    if (last_tog >= 0) begin
                        gap = cyc - last_tog;
                        if (gap < m_gap_min) m_gap_min = gap;
                        if (gap > m_gap_max) m_gap_max = gap;
                    end
                    last_tog = cyc;
                    if (sck_o) begin
                        m_rise++;
                        if (m_nrec < 64) m_mosi[m_nrec] = mosi_o;
                        m_nrec++;
                    end
                end
                if (nss_o !== exp_nss) m_nss_bad++;
            end else begin
                if (nss_o !== (ass_exp ? 4'b1111 : exp_nss)) m_nss_bad++;
            end
            prev_sck = sck_o;
            if (done_o) begin
                m_done++;
                m_rx = rx_data_o;
                if (post < 0) post = cyc;
            end
            if (post >= 0 && cyc >= post + 3) break;
            if (cyc >= max_cyc) begin
                m_timeout = 1'b1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; cpol_i = 1'b1; cpha_i = 1'b0; lsb_i = 1'b0;
        ass_i = 1'b0; nss_sel_i = 4'b1111; tx_data_i = '0; dtb_i = '0; div_i = '0;
        loop_en = 1'b0; miso_fix = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck_o); end
        checks++; if (nss_o !== 4'b1111) begin errors++; $display("FAIL reset_nss got %b want 1111", nss_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (rx_data_o !== 32'h0) begin errors++; $display("FAIL reset_rx got %h want 0", rx_data_o); end
        checks++; if (mosi_o !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_mode0();
        set_cfg(32'hA5, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        pulse_start();
        measure(400, 4'b1110, 1'b1, -1, 1'b0);
        checks++; if (m_done != 1) begin errors++; $display("FAIL m0_done got %0d want 1", m_done); end
        checks++; if (m_rx !== 32'h000000A5) begin errors++; $display("FAIL m0_rx got %h want 000000a5", m_rx); end
        checks++; if (m_busy != 18) begin errors++; $display("FAIL m0_busy got %0d want 18", m_busy); end
        checks++; if (m_rise != 8) begin errors++; $display("FAIL m0_rise got %0d want 8", m_rise); end
        checks++; if (m_nss_bad != 0) begin errors++; $display("FAIL m0_nss bad cycles %0d want 0", m_nss_bad); end
        checks++; if (m_gap_max != 1) begin errors++; $display("FAIL m0_gap got %0d want 1", m_gap_max); end
    endtask

    task automatic test_mode3();
        set_cfg(32'h1234, 2'd1, 8'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1);
        checks++; if (sck_o !== 1'b1) begin errors++; $display("FAIL m3_idle_sck got %b want 1", sck_o); end
        pulse_start();
        measure(400, 4'b1101, 1'b1, -1, 1'b0);
        checks++; if (m_rx !== 32'h0000FFFF) begin errors++; $display("FAIL m3_rx got %h want 0000ffff", m_rx); end
        checks++; if (m_busy != 136) begin errors++; $display("FAIL m3_busy got %0d want 136", m_busy); end
        checks++; if (m_tog != 32) begin errors++; $display("FAIL m3_edges got %0d want 32", m_tog); end
        checks++; if (m_gap_min != 4 || m_gap_max != 4) begin errors++; $display("FAIL m3_gap got %0d..%0d want 4..4", m_gap_min, m_gap_max); end
        checks++; if (m_mosi[15:0] !== 16'h1234) begin errors++; $display("FAIL m3_mosi_seq got %h want 1234", m_mosi[15:0]); end
        checks++; if (m_done != 1) begin errors++; $display("FAIL m3_done got %0d want 1", m_done); end
        checks++; if (sck_o !== 1'b1) begin errors++; $display("FAIL m3_end_sck got %b want 1", sck_o); end
    endtask

    task automatic test_cpha1_32();
        set_cfg(32'hDEADBEEF, 2'd3, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0);
        pulse_start();
        measure(400, 4'b1011, 1'b1, -1, 1'b0);
        checks++; if (m_rx !== 32'hDEADBEEF) begin errors++; $display("FAIL w32_rx got %h want deadbeef", m_rx); end
        checks++; if (m_busy != 132) begin errors++; $display("FAIL w32_busy got %0d want 132", m_busy); end
        checks++; if (m_done != 1) begin errors++; $display("FAIL w32_done got %0d want 1", m_done); end
        checks++; if (m_rise != 32) begin errors++; $display("FAIL w32_rise got %0d want 32", m_rise); end
        checks++; if (m_nss_bad != 0) begin errors++; $display("FAIL w32_nss bad cycles %0d want 0", m_nss_bad); end
    endtask

    task automatic test_ignore_start();
        set_cfg(32'h3C, 2'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        pulse_start();
        measure(400, 4'b1110, 1'b1, 10, 1'b1);
        checks++; if (m_done != 1) begin errors++; $display("FAIL ign_done got %0d want 1", m_done); end
        checks++; if (m_rx !== 32'h0000003C) begin errors++; $display("FAIL ign_rx got %h want 0000003c", m_rx); end
        checks++; if (m_busy != 36) begin errors++; $display("FAIL ign_busy got %0d want 36", m_busy); end
        checks++; if (m_rise != 8) begin errors++; $display("FAIL ign_rise got %0d want 8", m_rise); end
        checks++; if (m_gap_min != 2 || m_gap_max != 2) begin errors++; $display("FAIL ign_gap got %0d..%0d want 2..2", m_gap_min, m_gap_max); end
        checks++; if (m_nss_bad != 0) begin errors++; $display("FAIL ign_nss bad cycles %0d want 0", m_nss_bad); end
    endtask

    task automatic test_reset_mid();
        int   n;
        int   k;
        logic prev;
        set_cfg(32'h5A, 2'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        pulse_start();
        n = 0; k = 0; prev = sck_o;
        while (n < 5 && k < 200) begin
            @(negedge clk);
            if (sck_o !== prev) n++;
            prev = sck_o;
            k++;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rst_wait_edges got %0d want 5", n); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
        checks++; if (nss_o !== 4'b1111) begin errors++; $display("FAIL rst_nss got %b want 1111", nss_o); end
        checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL rst_sck got %b want 0", sck_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done_o); end
        checks++; if (rx_data_o !== 32'h0) begin errors++; $display("FAIL rst_rx got %h want 0", rx_data_o); end
        measure(40, 4'b1110, 1'b1, -1, 1'b0);
        checks++; if (m_done != 0 || m_busy != 0) begin errors++; $display("FAIL rst_quiet got done %0d busy %0d want 0 0", m_done, m_busy); end
        set_cfg(32'hA5, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0);
        pulse_start();
        measure(400, 4'b1110, 1'b1, -1, 1'b0);
        checks++; if (m_rx !== 32'h000000A5) begin errors++; $display("FAIL rst_again_rx got %h want 000000a5", m_rx); end
        checks++; if (m_busy != 18 || m_done != 1) begin errors++; $display("FAIL rst_again got busy %0d done %0d want 18 1", m_busy, m_done); end
    endtask

    task automatic test_manual_nss();
        set_cfg(32'h81, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0);
        checks++; if (nss_o !== 4'b1001) begin errors++; $display("FAIL man_idle_nss got %b want 1001", nss_o); end
        pulse_start();
        measure(400, 4'b1001, 1'b0, -1, 1'b0);
        checks++; if (m_nss_bad != 0) begin errors++; $display("FAIL man_nss bad cycles %0d want 0", m_nss_bad); end
        checks++; if (m_rx !== 32'h00000081) begin errors++; $display("FAIL man_rx got %h want 00000081", m_rx); end
        checks++; if (m_done != 1) begin errors++; $display("FAIL man_done got %0d want 1", m_done); end
        checks++; if (nss_o !== 4'b1001) begin errors++; $display("FAIL man_end_nss got %b want 1001", nss_o); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_cpha1_32();
        test_ignore_start();
        test_reset_mid();
        test_manual_nss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
